// File: rtl/alu_serial_responder.sv
// alu_serial_responder
//   DUT-side endpoint of the ALU serial protocol. Deserializes 11-bit frames
//   (start 0, type, 8 payload bits MSB first, stop 1) from sin, collects eight
//   data bytes as operands B and A, validates the command frame (length,
//   CRC4, opcode), runs the ALU operation and serializes either a result
//   packet (4 data frames + 1 command frame) or a single error frame on sout.
//
// Parameters
//   RESP_DELAY  idle cycles between command stop bit and response start (>= 1)
//
// Ports
//   clk      system clock, rising edge
//   rst_n    asynchronous active-low reset
//   sin      serial input, idles high
//   sout     serial output (registered), idles high
//   busy     high from command acceptance until after the last response stop bit
//   err_cnt  saturating count of error responses (only with ALU_RESP_ERR_COUNT_EN)
//
// Optional feature macro: ALU_RESP_ERR_COUNT_EN
module alu_serial_responder #(
    parameter int unsigned RESP_DELAY = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sin,
`ifdef ALU_RESP_ERR_COUNT_EN
    output logic [7:0] err_cnt,
`endif
    output logic       sout,
    output logic       busy
);

    localparam int unsigned WAIT_W = (RESP_DELAY < 2) ? 1 : $clog2(RESP_DELAY + 1);

    typedef enum logic {RX_IDLE, RX_FRAME} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_WAIT, TX_FRAME} tx_state_t;

    rx_state_t         rx_state, rx_state_d;
    logic [3:0]        rx_bit, rx_bit_d;
    logic              rx_type, rx_type_d;
    logic [7:0]        rx_byte, rx_byte_d;
    logic [3:0]        data_cnt, data_cnt_d;
    logic [63:0]       opnd_sr, opnd_sr_d;

    tx_state_t         tx_state, tx_state_d;
    logic [WAIT_W-1:0] wait_cnt, wait_cnt_d;
    logic [3:0]        tx_bit, tx_bit_d;
    logic [2:0]        frame_idx, frame_idx_d;
    logic [2:0]        last_idx, last_idx_d;
    logic [39:0]       resp_data, resp_data_d;
    logic              sout_d, busy_d;

    logic              cmd_accept;

    // ------------------------------------------------------------------
    // CRC helpers (MSB-first LFSR, init 0)
    // ------------------------------------------------------------------
    function automatic logic [3:0] crc4_calc(input logic [67:0] msg);
        logic [3:0]  c;
        logic [67:0] m;
        logic        fb;
        c = '0;
        m = msg;
        for (int unsigned i = 0; i < 68; i++) begin
            fb = c[3] ^ m[67];
            c  = {c[2:0], 1'b0} ^ (fb ? 4'b0011 : 4'b0000);
            m  = m << 1;
        end
        return c;
    endfunction

    function automatic logic [2:0] crc3_calc(input logic [36:0] msg);
        logic [2:0]  c;
        logic [36:0] m;
        logic        fb;
        c = '0;
        m = msg;
        for (int unsigned i = 0; i < 37; i++) begin
            fb = c[2] ^ m[36];
            c  = {c[1:0], 1'b0} ^ (fb ? 3'b011 : 3'b000);
            m  = m << 1;
        end
        return c;
    endfunction

    // ------------------------------------------------------------------
    // Command decode and ALU (valid while the command stop bit is sampled)
    // ------------------------------------------------------------------
    logic [31:0] op_b, op_a, alu_c;
    logic [2:0]  cmd_op;
    logic [3:0]  cmd_crc, flags;
    logic [32:0] sum33, dif33;
    logic        carry, ovf, op_ok;
    logic        e_data, e_crc, e_op, any_err;
    logic [5:0]  err6;
    logic [7:0]  err_payload;
    logic [2:0]  res_crc3;

    assign op_b    = opnd_sr[63:32];
    assign op_a    = opnd_sr[31:0];
    assign cmd_op  = rx_byte[6:4];
    assign cmd_crc = rx_byte[3:0];

    always_comb begin
        sum33 = {1'b0, op_b} + {1'b0, op_a};
        dif33 = {1'b0, op_b} - {1'b0, op_a};
        alu_c = '0;
        carry = 1'b0;
        ovf   = 1'b0;
        op_ok = 1'b1;
        case (cmd_op)
            3'b000: alu_c = op_b & op_a;
            3'b001: alu_c = op_b | op_a;
            3'b100: begin
                alu_c = sum33[31:0];
                carry = sum33[32];
                ovf   = (op_b[31] == op_a[31]) && (sum33[31] != op_b[31]);
            end
            3'b101: begin
                alu_c = dif33[31:0];
                carry = dif33[32];   // borrow out equals B < A unsigned
                ovf   = (op_b[31] != op_a[31]) && (dif33[31] != op_b[31]);
            end
            default: op_ok = 1'b0;
        endcase
        flags = {carry, ovf, (alu_c == '0), alu_c[31]};

        e_data  = (data_cnt != 4'd8);
        e_crc   = !e_data && (crc4_calc({op_b, op_a, 1'b1, cmd_op}) != cmd_crc);
        e_op    = !e_data && !e_crc && !op_ok;
        any_err = e_data || e_crc || e_op;
        err6        = {e_data, e_crc, e_op, e_data, e_crc, e_op};
        err_payload = {1'b1, err6, ^{1'b1, err6}};
        res_crc3    = crc3_calc({alu_c, 1'b0, flags});
    end

    // ------------------------------------------------------------------
    // Current transmit bit
    // ------------------------------------------------------------------
    logic [7:0] cur_byte;
    logic [2:0] bit_sel;
    logic       frame_bit;

    always_comb begin
        case (frame_idx)
            3'd0:    cur_byte = resp_data[39:32];
            3'd1:    cur_byte = resp_data[31:24];
            3'd2:    cur_byte = resp_data[23:16];
            3'd3:    cur_byte = resp_data[15:8];
            default: cur_byte = resp_data[7:0];
        endcase
        bit_sel   = 3'(4'd9 - tx_bit);
        frame_bit = 1'b1;
        if (tx_bit == 4'd1)
            frame_bit = (frame_idx == last_idx);   // only the final frame is a command frame
        else if (tx_bit >= 4'd2 && tx_bit <= 4'd9)
            frame_bit = cur_byte[bit_sel];
    end

    // ------------------------------------------------------------------
    // Next-state logic for RX and TX FSMs
    // ------------------------------------------------------------------
    always_comb begin
        rx_state_d  = rx_state;
        rx_bit_d    = rx_bit;
        rx_type_d   = rx_type;
        rx_byte_d   = rx_byte;
        data_cnt_d  = data_cnt;
        opnd_sr_d   = opnd_sr;
        tx_state_d  = tx_state;
        wait_cnt_d  = wait_cnt;
        tx_bit_d    = tx_bit;
        frame_idx_d = frame_idx;
        last_idx_d  = last_idx;
        resp_data_d = resp_data;
        sout_d      = sout;
        busy_d      = busy;
        cmd_accept  = 1'b0;

        case (rx_state)
            RX_IDLE: begin
                if (!sin && !busy) begin
                    rx_state_d = RX_FRAME;
                    rx_bit_d   = 4'd1;
                end
            end
            RX_FRAME: begin
                if (rx_bit == 4'd1)
                    rx_type_d = sin;
                else if (rx_bit != 4'd10)
                    rx_byte_d = {rx_byte[6:0], sin};

                if (rx_bit == 4'd10) begin
                    rx_state_d = RX_IDLE;
                    rx_bit_d   = '0;
                    if (!sin) begin
                        data_cnt_d = '0;
                    end else if (!rx_type) begin
                        // operand bytes are committed only on a good stop bit
                        opnd_sr_d = {opnd_sr[55:0], rx_byte};
                        if (data_cnt != 4'd9)
                            data_cnt_d = data_cnt + 4'd1;
                    end else begin
                        cmd_accept = 1'b1;
                        data_cnt_d = '0;
                    end
                end else begin
                    rx_bit_d = rx_bit + 4'd1;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase

        case (tx_state)
            TX_IDLE: ;
            TX_WAIT: begin
                if (wait_cnt == '0) begin
                    tx_state_d = TX_FRAME;
                    sout_d     = 1'b0;
                    tx_bit_d   = 4'd1;
                end else begin
                    wait_cnt_d = wait_cnt - 1'b1;
                end
            end
            TX_FRAME: begin
                if (tx_bit == 4'd11) begin
                    if (frame_idx == last_idx) begin
                        tx_state_d = TX_IDLE;
                        sout_d     = 1'b1;
                        busy_d     = 1'b0;
                    end else begin
                        frame_idx_d = frame_idx + 3'd1;
                        sout_d      = 1'b0;
                        tx_bit_d    = 4'd1;
                    end
                end else begin
                    sout_d   = frame_bit;
                    tx_bit_d = tx_bit + 4'd1;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase

        if (cmd_accept) begin
            busy_d      = 1'b1;
            tx_state_d  = TX_WAIT;
            wait_cnt_d  = WAIT_W'(RESP_DELAY);
            tx_bit_d    = '0;
            frame_idx_d = '0;
            if (any_err) begin
                resp_data_d = {err_payload, 32'h0};
                last_idx_d  = 3'd0;
            end else begin
                resp_data_d = {alu_c, 1'b0, flags, res_crc3};
                last_idx_d  = 3'd4;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state  <= RX_IDLE;
            rx_bit    <= '0;
            rx_type   <= 1'b0;
            rx_byte   <= '0;
            data_cnt  <= '0;
            opnd_sr   <= '0;
            tx_state  <= TX_IDLE;
            wait_cnt  <= '0;
            tx_bit    <= '0;
            frame_idx <= '0;
            last_idx  <= '0;
            resp_data <= '0;
            sout      <= 1'b1;
            busy      <= 1'b0;
        end else begin
            rx_state  <= rx_state_d;
            rx_bit    <= rx_bit_d;
            rx_type   <= rx_type_d;
            rx_byte   <= rx_byte_d;
            data_cnt  <= data_cnt_d;
            opnd_sr   <= opnd_sr_d;
            tx_state  <= tx_state_d;
            wait_cnt  <= wait_cnt_d;
            tx_bit    <= tx_bit_d;
            frame_idx <= frame_idx_d;
            last_idx  <= last_idx_d;
            resp_data <= resp_data_d;
            sout      <= sout_d;
            busy      <= busy_d;
        end
    end

`ifdef ALU_RESP_ERR_COUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_cnt <= '0;
        else if (cmd_accept && any_err && (err_cnt != 8'hFF))
            err_cnt <= err_cnt + 8'd1;
    end
`endif

endmodule

// File: tb/tb_alu_serial_responder.sv
// Self-checking bench for alu_serial_responder: directed test-plan cases plus
// randomized transactions, with a behavioural model that predicts busy/sout
// on every cycle.
module tb_alu_serial_responder;

    localparam int RD = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic sin   = 1'b1;
    logic sout, busy;
`ifdef ALU_RESP_ERR_COUNT_EN
    logic [7:0] err_cnt;
    int exp_err_cnt = 0;
`endif

    always #5 clk = ~clk;

    alu_serial_responder #(.RESP_DELAY(RD)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .sin    (sin),
`ifdef ALU_RESP_ERR_COUNT_EN
        .err_cnt(err_cnt),
`endif
        .sout   (sout),
        .busy   (busy)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;     // number of rising edges so far
    int nfail_print = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Model state
    bit [7:0] rx_bytes[$];   // data bytes accepted since last clear
    bit       exp_active = 1'b0;
    int       exp_e0     = 0; // edge at which the command stop bit was sampled
    bit       exp_bits[$];    // expected serial response bit stream

    function automatic void chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            if (nfail_print < 40) begin
                nfail_print++;
                $display("FAIL %s t=%0t got=%0h exp=%0h", name, $time, got, exp);
            end
        end
    endfunction

    // CRC as polynomial long division remainder
    function automatic bit [3:0] crc4_ref(input bit [67:0] m);
        bit [71:0] w;
        w = {m, 4'b0000};
        for (int i = 71; i >= 4; i--)
            if (w[i]) w[i -: 5] ^= 5'b10011;
        return w[3:0];
    endfunction

    function automatic bit [2:0] crc3_ref(input bit [36:0] m);
        bit [39:0] w;
        w = {m, 3'b000};
        for (int i = 39; i >= 3; i--)
            if (w[i]) w[i -: 4] ^= 4'b1011;
        return w[2:0];
    endfunction

    // Returns {C, carry, overflow, zero, negative}
    function automatic bit [35:0] alu_ref(input bit [2:0] op, input bit [31:0] b, input bit [31:0] a);
        bit [31:0] c;
        bit        cy, ov;
        longint    s;
        c = 0; cy = 0; ov = 0;
        case (op)
            3'b000: c = b & a;
            3'b001: c = b | a;
            3'b100: begin
                c  = b + a;
                cy = (longint'(b) + longint'(a)) > longint'(64'hFFFF_FFFF);
                s  = longint'($signed(b)) + longint'($signed(a));
                ov = (s > longint'(32'sh7FFF_FFFF)) || (s < longint'(32'sh8000_0000));
            end
            3'b101: begin
                c  = b - a;
                cy = b < a;
                s  = longint'($signed(b)) - longint'($signed(a));
                ov = (s > longint'(32'sh7FFF_FFFF)) || (s < longint'(32'sh8000_0000));
            end
            default: ;
        endcase
        return {c, cy, ov, (c == 0), c[31]};
    endfunction

    function automatic bit [7:0] err_pay(input bit ed, input bit ec, input bit eo);
        bit [6:0] p7;
        p7 = {1'b1, ed, ec, eo, ed, ec, eo};
        return {p7, bit'($countones(p7) % 2)};
    endfunction

    function automatic void push_frame(input bit typ, input bit [7:0] pay);
        exp_bits.push_back(1'b0);
        exp_bits.push_back(typ);
        for (int i = 7; i >= 0; i--) exp_bits.push_back(pay[i]);
        exp_bits.push_back(1'b1);
    endfunction

    task automatic model_command(input bit [2:0] op, input bit [3:0] crc, input int e0);
        bit [31:0] b, a;
        bit        ed, ec, eo;
        bit [35:0] r;
        b = 0; a = 0;
        ed = (rx_bytes.size() != 8);
        if (!ed) begin
            b = {rx_bytes[0], rx_bytes[1], rx_bytes[2], rx_bytes[3]};
            a = {rx_bytes[4], rx_bytes[5], rx_bytes[6], rx_bytes[7]};
        end
        ec = !ed && (crc4_ref({b, a, 1'b1, op}) != crc);
        eo = !ed && !ec && !(op inside {3'b000, 3'b001, 3'b100, 3'b101});
        exp_bits.delete();
        if (ed || ec || eo) begin
            push_frame(1'b1, err_pay(ed, ec, eo));
`ifdef ALU_RESP_ERR_COUNT_EN
            if (exp_err_cnt < 255) exp_err_cnt++;
`endif
        end else begin
            r = alu_ref(op, b, a);
            push_frame(1'b0, r[35:28]);
            push_frame(1'b0, r[27:20]);
            push_frame(1'b0, r[19:12]);
            push_frame(1'b0, r[11:4]);
            push_frame(1'b1, {1'b0, r[3:0], crc3_ref({r[35:4], 1'b0, r[3:0]})});
        end
        exp_e0     = e0;
        exp_active = 1'b1;
    endtask

    // Per-cycle comparison of busy and sout against the model
    always @(negedge clk) begin : compare
        bit eb, es;
        int rel;
        if (rst_n) begin
            eb = 1'b0;
            es = 1'b1;
            if (exp_active) begin
                rel = cyc - exp_e0;
                if (rel >= 0 && rel <= RD + exp_bits.size()) begin
                    eb = 1'b1;
                    if (rel >= RD + 1) es = exp_bits[rel - RD - 1];
                end
            end
            chk("busy", 64'(busy), 64'(eb));
            chk("sout", 64'(sout), 64'(es));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            sin = 1'b1;
        end
    endtask

    task automatic drive_frame(input bit typ, input bit [7:0] pay, input bit stop);
        bit [10:0] f;
        f = {1'b0, typ, pay, stop};
        for (int i = 10; i >= 0; i--) begin
            @(negedge clk);
            sin = f[i];
        end
    endtask

    task automatic send_data(input bit [7:0] byt, input bit stop);
        drive_frame(1'b0, byt, stop);
        if (stop) rx_bytes.push_back(byt);
        else      rx_bytes.delete();
    endtask

    // Idles until the predicted response has finished; optionally sends a
    // frame while busy, which the responder must ignore.
    task automatic wait_resp(input bit junk);
        int n;
        n = RD + exp_bits.size() + 2;
        if (junk) begin
            idle(1);
            drive_frame(1'b0, 8'($urandom), 1'b1);
            n -= 12;
        end
        idle(n);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #2;
        rst_n      = 1'b0;
        exp_active = 1'b0;
        rx_bytes.delete();
`ifdef ALU_RESP_ERR_COUNT_EN
        exp_err_cnt = 0;
`endif
        #1;
        chk("rst_sout", 64'(sout), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic txn(input bit [31:0] b, input bit [31:0] a, input bit [2:0] op,
                       input int ndata, input bit bad_crc, input bit abort_first,
                       input bit cmd_stop, input bit junk, input int reset_after);
        bit [63:0] ba;
        bit [3:0]  crc;
        ba = {b, a};
        if (abort_first) begin
            send_data(8'($urandom), 1'b0);
            idle($urandom_range(0, 2));
        end
        for (int i = 0; i < ndata; i++) begin
            send_data(ba[63 - 8 * (i % 8) -: 8], 1'b1);
            idle($urandom_range(0, 2));
        end
        crc = crc4_ref({b, a, 1'b1, op});
        if (bad_crc) crc ^= 4'($urandom_range(1, 15));
        drive_frame(1'b1, {1'b0, op, crc}, cmd_stop);
        if (!cmd_stop) begin
            rx_bytes.delete();
            idle(2);
        end else begin
            model_command(op, crc, cyc + 1);
            rx_bytes.delete();
            if (reset_after > 0) begin
                repeat (reset_after) @(negedge clk);
                pulse_reset();
            end else begin
                wait_resp(junk);
            end
        end
        idle($urandom_range(1, 3));
    endtask

    function automatic bit [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            4: return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        bit [2:0] valid_ops[4];
        valid_ops = '{3'b000, 3'b001, 3'b100, 3'b101};

        // Literal pins on the model
        chk("pin_add_ovf",  64'(alu_ref(3'b100, 32'h7FFF_FFFF, 32'h1)), 64'({32'h8000_0000, 4'b0101}));
        chk("pin_sub_brw",  64'(alu_ref(3'b101, 32'h0, 32'h1)),         64'({32'hFFFF_FFFF, 4'b1001}));
        chk("pin_add_wrap", 64'(alu_ref(3'b100, 32'hFFFF_FFFF, 32'h1)), 64'({32'h0, 4'b1010}));
        chk("pin_and",      64'(alu_ref(3'b000, 32'hFFFF_FFFF, 32'h0F0F_0F0F)), 64'({32'h0F0F_0F0F, 4'b0000}));
        chk("pin_or_zero",  64'(alu_ref(3'b001, 32'h0, 32'h0)),         64'({32'h0, 4'b0010}));
        chk("pin_err_data", 64'(err_pay(1, 0, 0)), 64'h C9);
        chk("pin_err_crc",  64'(err_pay(0, 1, 0)), 64'h A5);
        chk("pin_err_op",   64'(err_pay(0, 0, 1)), 64'h 93);
        chk("pin_crc4_x4",  64'(crc4_ref(68'h1)), 64'h3);
        chk("pin_crc4_x5",  64'(crc4_ref(68'h2)), 64'h6);
        chk("pin_crc3_x3",  64'(crc3_ref(37'h1)), 64'h3);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_sout", 64'(sout), 64'd1);
        chk("reset_busy", 64'(busy), 64'd0);
`ifdef ALU_RESP_ERR_COUNT_EN
        chk("reset_errcnt", 64'(err_cnt), 64'd0);
`endif
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        idle(3);

        // Directed cases
        txn(32'h7FFF_FFFF, 32'h0000_0001, 3'b100, 8, 0, 0, 1, 0, 0);
        txn(32'h0000_0000, 32'h0000_0001, 3'b101, 8, 0, 0, 1, 0, 0);
        txn(32'hFFFF_FFFF, 32'h0000_0001, 3'b100, 8, 0, 0, 1, 1, 0);
        txn(32'hFFFF_FFFF, 32'h0F0F_0F0F, 3'b000, 8, 0, 0, 1, 0, 0);
        txn(32'h0000_0000, 32'h0000_0000, 3'b001, 8, 0, 0, 1, 0, 0);
        txn(32'h1234_5678, 32'h9ABC_DEF0, 3'b100, 7, 0, 0, 1, 0, 0);   // short
        txn(32'h1234_5678, 32'h9ABC_DEF0, 3'b100, 10, 0, 0, 1, 0, 0);  // long, saturates
        txn(32'h1234_5678, 32'h9ABC_DEF0, 3'b100, 8, 1, 0, 1, 1, 0);   // bad CRC
        txn(32'h1234_5678, 32'h9ABC_DEF0, 3'b010, 8, 0, 0, 1, 0, 0);   // bad op
        txn(32'hDEAD_BEEF, 32'h0BAD_F00D, 3'b100, 8, 0, 1, 1, 0, 0);   // aborted frame first
        txn(32'hCAFE_0000, 32'h0000_BABE, 3'b101, 8, 0, 0, 0, 0, 0);   // command stop 0
        txn(32'hCAFE_0000, 32'h0000_BABE, 3'b101, 8, 0, 0, 1, 0, 0);
        txn(32'h0101_0101, 32'h1010_1010, 3'b100, 8, 0, 0, 1, 0, 20);  // reset mid-response
        txn(32'h0101_0101, 32'h1010_1010, 3'b100, 8, 0, 0, 1, 0, 0);

        // Randomized transactions
        for (int t = 0; t < 40; t++) begin
            bit [2:0] op;
            int       nd;
            op = ($urandom_range(0, 99) < 85) ? valid_ops[$urandom_range(0, 3)] : 3'($urandom);
            nd = ($urandom_range(0, 99) < 85) ? 8 : $urandom_range(0, 10);
            txn(pick_operand(), pick_operand(), op, nd,
                $urandom_range(0, 99) < 10,
                $urandom_range(0, 99) < 10,
                $urandom_range(0, 99) >= 5,
                $urandom_range(0, 99) < 20,
                ($urandom_range(0, 99) < 5) ? $urandom_range(3, 40) : 0);
        end

        idle(5);
`ifdef ALU_RESP_ERR_COUNT_EN
        chk("err_cnt", 64'(err_cnt), 64'(exp_err_cnt));
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_serial_responder.md
Name: alu_serial_responder

Overview:
- DUT-side endpoint of the ALU serial protocol.
- Deserializes operand and command frames from `sin` and checks CRC4, length and opcode.
- Computes the 32-bit ALU result and serializes either a result packet or an error packet onto `sout`.
- Sits between the ALU BFM serial pins and the arithmetic core. It is the synthesizable counterpart of the stimulus side.

Parameters:
- RESP_DELAY, default 2: idle cycles between the command frame's stop bit and the response start bit (minimum 1).

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst_n  input  1  asynchronous, active-low reset
- sin  input  1  serial input; idles high
- sout  output  1  serial output; idles high
- busy  output  1  high from command-frame acceptance until the last response stop bit

Behaviour:
- Frame format (11 bits, one bit per clk): start 0, type (0 = data, 1 = command), 8 payload bits MSB first, stop 1.
- Reset: sout=1, busy=0, receive and transmit FSMs to IDLE, data counter=0, operand shift register cleared.
- RX FSM transitions:
  - RX_IDLE to RX_FRAME on sin==0.
  - RX_FRAME counts bits 1..10, then returns to RX_IDLE.
  - No start bit is accepted while busy=1.
- Data frames: payload shifts into a 64-bit register; data counter increments and saturates at 9.
  - The first four bytes form B[31:24..7:0]; the next four form A.
- Stop bit sampled 0: the frame is discarded, data counter is cleared, and no response is sent.
- Command frame payload {1'b0, op[2:0], crc4[3:0]}. On its valid stop bit, busy rises next cycle and checks run in priority order:
  - 1. ERR_DATA if data count != 8.
  - 2. ERR_CRC if crc4 != CRC4(x^4+x+1, init 0, MSB first) over {B, A, 1'b1, op} (68 bits).
  - 3. ERR_OP if op not in {000 AND, 001 OR, 100 ADD, 101 SUB}.
- Only the highest-priority error is reported. The data counter clears after every command frame.
- ALU operations:
  - AND: C = B & A.
  - OR: C = B | A.
  - ADD: C = B + A; carry = bit 32.
  - SUB: C = B - A; carry = borrow (B < A unsigned).
  - Overflow is the signed overflow for ADD/SUB and 0 for logic ops.
  - Zero = (C == 0); negative = C[31].
  - flags = {carry, overflow, zero, negative}.
- Result response: 5 back-to-back frames.
  - Four data frames carrying C, MSB byte first.
  - One command frame with payload {1'b0, flags[3:0], crc3[2:0]}, where crc3 = CRC3(x^3+x+1, init 0, MSB first) over {C, 1'b0, flags} (37 bits).
- Error response: one command frame with payload {1'b1, err[5:0], parity}.
  - err = {ERR_DATA, ERR_CRC, ERR_OP, ERR_DATA, ERR_CRC, ERR_OP}.
  - parity = XOR of the preceding 7 payload bits (even parity).
- TX FSM:
  - TX_IDLE, then TX_WAIT for RESP_DELAY cycles, then TX_FRAME over 11 bits per frame, repeating until all frames are sent, then TX_IDLE.
  - The response start bit appears on the (RESP_DELAY+1)-th edge after the command stop bit is sampled.
  - busy falls on the cycle after the last stop bit.
  - sout is registered.
- Async reset mid-frame or mid-response aborts immediately to reset values. No partial frame resumes.

Optional Feature:
- Macro ALU_RESP_ERR_COUNT_EN.
- Defined: adds output err_cnt [7:0], reset 0, incremented once per error response and saturating at 255.
- Undefined: the port and counter are absent, and behaviour is otherwise identical.

Test Plan:
- ADD, B=0x7FFFFFFF, A=0x00000001, valid CRC -> C bytes 80,00,00,00; flags 0101; crc3 matches the model.
- SUB, B=0x00000000, A=0x00000001 -> C=0xFFFFFFFF, flags 1001; ADD, B=0xFFFFFFFF, A=0x00000001 -> C=0, flags 1010.
- AND, B=0xFFFFFFFF, A=0x0F0F0F0F -> C=0x0F0F0F0F, flags 0000; OR, B=0, A=0 -> C=0, flags 0010.
- Seven data frames, then a command -> single error frame with payload 0xC9. Valid length with bad CRC -> 0xA5. Valid CRC with op=010 -> 0x93.
- Data frame with stop bit 0, then 8 valid data frames and an ADD command -> normal result; the aborted frame is not counted.
- rst_n pulsed low mid-response -> sout=1 and busy=0 immediately; the next valid transaction returns the correct result.
